// File: rtl/phase_demand_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : phase_demand_scheduler
// Description : Three-phase traffic signal scheduler (A = main through,
//               B = main turn, C = branch). Each phase is served on latched
//               vehicle demand, with min/max green, yellow and all-red
//               clearance, and a pedestrian walk that runs during phase C
//               green.
// Ports       : clk       - clock, all state changes on the rising edge
//               rst       - synchronous active-high reset
//               req[2:0]  - level vehicle demand per phase (bit0 = A)
//               ped_req   - pedestrian push-button
//               green     - one-hot green per phase
//               yellow    - one-hot yellow per phase
//               all_red   - all-red clearance indication
//               ped_walk  - walk indication (phase C green only)
//               cur_phase - phase owning green/yellow (0=A, 1=B, 2=C)
// Revision    : 1.0 - initial release
// ============================================================================
module phase_demand_scheduler #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       ped_req,
  output logic [2:0] green,
  output logic [2:0] yellow,
  output logic       all_red,
  output logic       ped_walk,
  output logic [1:0] cur_phase
);

  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_ALLRED = 2'd2;

  localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST    = 8'(MAX_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);
  localparam logic [7:0] CNT_SAT     = 8'(MAX_GREEN);

  logic [1:0] state;
  logic [1:0] cur;
  logic [7:0] cnt;
  logic [2:0] pending;
  logic       ped_pending;
  logic       walk;

  function automatic logic [2:0] onehot(input logic [1:0] p);
    case (p)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] succ(input logic [1:0] p);
    succ = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [2:0] cur_oh;
  logic       other_pending;
  logic       cur_req;
  logic       walk_hold;
  logic       green_exit;
  logic       yellow_exit;
  logic       allred_exit;
  logic       transition;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] next_cur;
  logic       ped_accept;
  logic       walk_start;
  logic [2:0] pending_set;
  logic [2:0] pending_nxt;

  always_comb begin
    cur_oh        = onehot(cur);
    other_pending = |(pending & ~cur_oh);
    cur_req       = |(req & cur_oh);
    // A running walk pins phase C green until the walk interval is complete.
    walk_hold     = walk && (cur == 2'd2) && (cnt < WALK_LAST);
    green_exit    = (state == S_GREEN) && other_pending && !walk_hold &&
                    (((cnt >= MIN_LAST) && !cur_req) || (cnt >= MAX_LAST));
    yellow_exit   = (state == S_YELLOW) && (cnt >= YELLOW_LAST);
    allred_exit   = (state == S_ALLRED) && (cnt >= ALLRED_LAST);
    transition    = green_exit || yellow_exit || allred_exit;

    // Round-robin pick starting after the current phase; if nothing is
    // pending (only possible in corner cases) return to the current phase.
    cand1 = succ(cur);
    cand2 = succ(cand1);
    if (|(pending & onehot(cand1)))      next_cur = cand1;
    else if (|(pending & onehot(cand2))) next_cur = cand2;
    else                                 next_cur = cur;

    ped_accept = ped_req && !walk;
    walk_start = allred_exit && (next_cur == 2'd2) && ped_pending;

    // The phase currently showing green does not latch its own demand.
    pending_set = (req & ((state == S_GREEN) ? ~cur_oh : 3'b111)) |
                  {ped_accept, 2'b00};
    pending_nxt = pending | pending_set;
    // Entry into green clears that phase's bit, overriding a same-edge set.
    if (allred_exit) pending_nxt = pending_nxt & ~onehot(next_cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_GREEN;
      cur         <= 2'd0;
      cnt         <= 8'd0;
      pending     <= 3'b000;
      ped_pending <= 1'b0;
      walk        <= 1'b0;
    end else begin
      pending <= pending_nxt;

      if (transition)          cnt <= 8'd0;
      else if (cnt < CNT_SAT)  cnt <= cnt + 8'd1;

      case (state)
        S_GREEN:  if (green_exit)  state <= S_YELLOW;
        S_YELLOW: if (yellow_exit) state <= S_ALLRED;
        S_ALLRED: if (allred_exit) state <= S_GREEN;
        default:                   state <= S_GREEN;
      endcase

      if (allred_exit) cur <= next_cur;

      if (walk_start)      ped_pending <= 1'b0;
      else if (ped_accept) ped_pending <= 1'b1;

      if (walk_start)
        walk <= 1'b1;
      else if ((state != S_GREEN) || (cnt >= WALK_LAST))
        walk <= 1'b0;
    end
  end

  always_comb begin
    green     = (state == S_GREEN)  ? cur_oh : 3'b000;
    yellow    = (state == S_YELLOW) ? cur_oh : 3'b000;
    all_red   = (state == S_ALLRED);
    ped_walk  = walk;
    cur_phase = cur;
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_demand_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_demand_scheduler
// Description : Directed self-checking bench for phase_demand_scheduler
//               with hand-computed per-cycle light sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_demand_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       ped_req = 1'b0;
  logic [2:0] green;
  logic [2:0] yellow;
  logic       all_red;
  logic       ped_walk;
  logic [1:0] cur_phase;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] GA = 7'b001_000_0;
  localparam logic [6:0] GB = 7'b010_000_0;
  localparam logic [6:0] GC = 7'b100_000_0;
  localparam logic [6:0] YA = 7'b000_001_0;
  localparam logic [6:0] YB = 7'b000_010_0;
  localparam logic [6:0] YC = 7'b000_100_0;
  localparam logic [6:0] AR = 7'b000_000_1;

  phase_demand_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ped_req   (ped_req),
    .green     (green),
    .yellow    (yellow),
    .all_red   (all_red),
    .ped_walk  (ped_walk),
    .cur_phase (cur_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req = 3'b000;
    ped_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] lights();
    return {green, yellow, all_red};
  endfunction

  logic [6:0] exp_l;
  logic [1:0] exp_p;

  initial begin
    // Reset state, then green A -> C with C demand held from cycle 0.
    reset_dut();
    check("reset_outputs", {25'd0, green, yellow, all_red, ped_walk},
          {25'd0, 3'b001, 3'b000, 1'b0, 1'b0});
    check("reset_phase", {30'd0, cur_phase}, 32'd0);
    req = 3'b100;
    for (int c = 0; c <= 30; c++) begin
      if (c <= 7)       begin exp_l = GA; exp_p = 2'd0; end
      else if (c <= 10) begin exp_l = YA; exp_p = 2'd0; end
      else if (c <= 12) begin exp_l = AR; exp_p = 2'd0; end
      else              begin exp_l = GC; exp_p = 2'd2; end
      check($sformatf("t1_lights_c%0d", c), {25'd0, lights()}, {25'd0, exp_l});
      check($sformatf("t1_phase_c%0d", c), {30'd0, cur_phase}, {30'd0, exp_p});
      tick();
    end

    // Held A demand with B pulse: green A capped at max green.
    reset_dut();
    req = 3'b001;
    for (int c = 0; c <= 25; c++) begin
      if (c == 2) req = 3'b011;
      if (c == 3) req = 3'b001;
      if (c <= 19)      exp_l = GA;
      else if (c <= 22) exp_l = YA;
      else if (c <= 24) exp_l = AR;
      else              exp_l = GB;
      check($sformatf("t2_lights_c%0d", c), {25'd0, lights()}, {25'd0, exp_l});
      tick();
    end
    check("t2_phase_b", {30'd0, cur_phase}, 32'd1);

    // B and C pulsed together: serve B, then C, then rest on C.
    reset_dut();
    for (int c = 0; c <= 45; c++) begin
      if (c == 1) req = 3'b110;
      if (c == 2) req = 3'b000;
      if (c <= 7)       begin exp_l = GA; exp_p = 2'd0; end
      else if (c <= 10) begin exp_l = YA; exp_p = 2'd0; end
      else if (c <= 12) begin exp_l = AR; exp_p = 2'd0; end
      else if (c <= 20) begin exp_l = GB; exp_p = 2'd1; end
      else if (c <= 23) begin exp_l = YB; exp_p = 2'd1; end
      else if (c <= 25) begin exp_l = AR; exp_p = 2'd1; end
      else              begin exp_l = GC; exp_p = 2'd2; end
      check($sformatf("t3_lights_c%0d", c), {25'd0, lights()}, {25'd0, exp_l});
      check($sformatf("t3_phase_c%0d", c), {30'd0, cur_phase}, {30'd0, exp_p});
      tick();
    end

    // Pedestrian pulse: C served with 5-cycle walk; a press during the walk
    // is dropped, so after returning to A nothing pulls C back.
    reset_dut();
    for (int c = 0; c <= 45; c++) begin
      ped_req = (c == 1) || (c == 15);
      req     = (c == 19) ? 3'b001 : 3'b000;
      if (c <= 7)       exp_l = GA;
      else if (c <= 10) exp_l = YA;
      else if (c <= 12) exp_l = AR;
      else if (c <= 20) exp_l = GC;
      else if (c <= 23) exp_l = YC;
      else if (c <= 25) exp_l = AR;
      else              exp_l = GA;
      check($sformatf("t4_lights_c%0d", c), {25'd0, lights()}, {25'd0, exp_l});
      check($sformatf("t4_walk_c%0d", c), {31'd0, ped_walk},
            {31'd0, (c >= 13) && (c <= 17)});
      tick();
    end
    ped_req = 1'b0;
    req = 3'b000;

    // Reset during the second yellow cycle returns to green A with nothing
    // pending, so A then rests.
    reset_dut();
    req = 3'b100;
    for (int c = 0; c <= 40; c++) begin
      if (c == 9)  rst = 1'b1;
      if (c == 10) begin rst = 1'b0; req = 3'b000; end
      if (c <= 7)      exp_l = GA;
      else if (c <= 9) exp_l = YA;
      else             exp_l = GA;
      check($sformatf("t5_lights_c%0d", c), {25'd0, lights()}, {25'd0, exp_l});
      if (c == 10)
        check("t5_phase_after_rst", {30'd0, cur_phase}, 32'd0);
      tick();
    end

    // No demand, then only A demand: green A throughout.
    reset_dut();
    for (int c = 0; c < 100; c++) begin
      req = (c < 50) ? 3'b000 : 3'b001;
      check($sformatf("t6_lights_c%0d", c), {25'd0, lights()}, {25'd0, GA});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
